// File: rtl/stream_hmedian3_if.sv
// Avalon-ST style video stream bundle: data/valid/ready plus packet framing.
// The master drives data, valid, sop and eop; the slave drives ready.
interface stream_hmedian3_if;
   logic [23:0] data;
   logic        valid;
   logic        ready;
   logic        sop;
   logic        eop;

   modport master (output data, output valid, output sop, output eop, input ready);
   modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/stream_hmedian3.sv
// 3-tap horizontal median on 24-bit RGB video, per 8-bit channel, edges replicated.
// Headers and non-video packets pass through with one cycle of latency.
module stream_hmedian3 #(
   parameter logic [10:0] IMAGE_W    = 11'd640,
   parameter bit          MED_BYPASS = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   stream_hmedian3_if.slave         sink,
   stream_hmedian3_if.master        source,
   output logic [1:0]               o_dbg_state
);

   // Handshake: a word moves on either side only in a cycle where valid & ready are
   // both high at the rising edge. source_valid/data/sop/eop are registered and stay
   // stable while source_valid & ~source_ready. sink_ready is low during FLUSH, and
   // also low for one cycle when a sop shows up while a pixel is still held.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD1 = 2'd1,
      ST_HOLD2 = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_video;
   logic [10:0] r_x;
   logic [23:0] r_cur;
   logic [23:0] r_prev;
   logic        r_cur_eop;
   logic [23:0] r_out_data;
   logic        r_out_valid;
   logic        r_out_sop;
   logic        r_out_eop;

   logic        w_load_ok;
   logic        w_holding;
   logic        w_sop_break;
   logic        w_sink_ready;
   logic        w_accept;
   logic        w_last;
   logic        w_filter_on;
   logic [10:0] w_x_next;
   logic [23:0] w_med;
   logic [23:0] w_hold2_out;

   function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
      logic [7:0] lo_ab;
      logic [7:0] hi_ab;
      logic [7:0] lo_hc;
      lo_ab = (a < b) ? a : b;
      hi_ab = (a < b) ? b : a;
      lo_hc = (hi_ab < c) ? hi_ab : c;
      return (lo_ab > lo_hc) ? lo_ab : lo_hc;
   endfunction

   assign w_load_ok    = ~r_out_valid | source.ready;
   assign w_holding    = (r_state == ST_HOLD1) | (r_state == ST_HOLD2);
   assign w_sop_break  = w_holding & sink.valid & sink.sop;
   assign w_sink_ready = w_load_ok & (r_state != ST_FLUSH) & ~w_sop_break;
   assign w_accept     = sink.valid & w_sink_ready;
   assign w_last       = (r_x == IMAGE_W - 11'd1) | sink.eop;
   assign w_x_next     = (r_x == IMAGE_W - 11'd1) ? 11'd0 : r_x + 11'd1;
   assign w_filter_on  = enable & ~MED_BYPASS;

   assign w_med = {med3(r_prev[23:16], r_cur[23:16], sink.data[23:16]),
                   med3(r_prev[15:8],  r_cur[15:8],  sink.data[15:8]),
                   med3(r_prev[7:0],   r_cur[7:0],   sink.data[7:0])};
   assign w_hold2_out = w_filter_on ? w_med : r_cur;

   assign sink.ready    = w_sink_ready;
   assign source.data   = r_out_data;
   assign source.valid  = r_out_valid;
   assign source.sop    = r_out_sop;
   assign source.eop    = r_out_eop;
   assign o_dbg_state   = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_video     <= 1'b0;
         r_x         <= 11'd0;
         r_cur       <= 24'd0;
         r_prev      <= 24'd0;
         r_cur_eop   <= 1'b0;
         r_out_data  <= 24'd0;
         r_out_valid <= 1'b0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
      end else if (w_load_ok) begin
         r_out_valid <= 1'b0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (sink.sop) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= sink.data;
                     r_out_sop   <= 1'b1;
                     r_out_eop   <= sink.eop;
                     r_video     <= (sink.data[3:0] == 4'h0) & ~sink.eop;
                     r_x         <= 11'd0;
                  end else if (r_video) begin
                     // First pixel of a row is held until its right neighbour arrives.
                     r_cur     <= sink.data;
                     r_cur_eop <= sink.eop;
                     r_x       <= w_x_next;
                     r_state   <= w_last ? ST_FLUSH : ST_HOLD1;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= sink.data;
                     r_out_eop   <= sink.eop;
                  end
               end
            end
            ST_HOLD1, ST_HOLD2: begin
               if (w_sop_break) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_cur;
                  r_x         <= 11'd0;
                  r_state     <= ST_IDLE;
               end else if (w_accept) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= (r_state == ST_HOLD1) ? r_cur : w_hold2_out;
                  r_prev      <= r_cur;
                  r_cur       <= sink.data;
                  r_cur_eop   <= sink.eop;
                  r_x         <= w_x_next;
                  r_state     <= w_last ? ST_FLUSH : ST_HOLD2;
               end
            end
            ST_FLUSH: begin
               // Right edge replicates, so the held pixel goes out unchanged.
               r_out_valid <= 1'b1;
               r_out_data  <= r_cur;
               r_out_eop   <= r_cur_eop;
               r_x         <= 11'd0;
               r_state     <= ST_IDLE;
               if (r_cur_eop) begin
                  r_video <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
